uart_tx_word: RTL and testbench
===============================

Name: uart_tx_word

Overview:
- Parametrised single-clock UART transmitter: accepts DATA_W-bit words into an internal FIFO and serialises each word as DATA_W/8 framed bytes, LSB byte first, LSB bit first.
- Adds over the previous TX generation: full-word serialisation, runtime baud divisor, configurable stop bits, and per-byte flow control from the downstream receiver.

Parameters:
- DATA_W, 32, input word width; multiple of 8; BYTES = DATA_W/8.
- FIFO_DEPTH, 16, word entries; power of two, at least 2.
- DIV_W, 16, width of baud_div.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when the parity feature is compiled in (0 = even, 1 = odd).

Ports:
- tx_clk_in  in  1  sole clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W  write data.
- wr_en  in  1  write strobe; pushes din when full is low.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  one-cycle pulse when wr_en is high while full (write dropped).
- rx_fifo_full_in  in  1  downstream hold; checked only before each start bit.
- baud_div  in  DIV_W  clocks per bit; latched at each word pop.
- serial_out  out  1  TX line, idle high.
- busy  out  1  high from pop until the last stop bit of the word completes.

Behaviour:
- Reset values: serial_out=1, busy=0, full=0, empty=1, level=0, overflow=0; state=IDLE.
- Reset clears FIFO contents and pointers.
- Reset mid-frame: line returns high immediately (asynchronous) and the partial word is discarded.
- FIFO write:
  - wr_en && !full pushes din; level increments.
  - Simultaneous push and pop in one cycle leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Write while full is dropped and pulses overflow; FIFO contents untouched.
- Divisor: latched value div_q = max(baud_div, 2). Every bit, including start, parity and stop bits, lasts exactly div_q clocks. baud_div changes mid-word have no effect.
- States: IDLE, START, DATA, PARITY, STOP, HOLD.
  - IDLE:
    - Transition condition: !empty && !rx_fifo_full_in.
    - Actions on that edge: pop the word into the shift register, latch div_q, clear byte_idx.
    - Outputs and next state on that edge: serial_out<=0, busy<=1, go to START.
  - START: hold 0 for div_q clocks, then go to DATA with serial_out<=bit0.
  - DATA: 8 bits, each div_q clocks; bit counter 0..7. After bit7, go to PARITY if compiled in, else STOP.
  - PARITY: one bit time; the parity bit covers the 8 data bits of the current byte.
  - STOP: serial_out=1 for STOP_BITS*div_q clocks, then:
    - byte_idx < BYTES-1: increment byte_idx, shift the word down by 8, go to HOLD.
    - otherwise: busy<=0, go to IDLE.
  - HOLD: if !rx_fifo_full_in, serial_out<=0 and go to START on the same edge; else wait with line high (busy stays 1).
- Latency: with an empty FIFO and hold low, a write on edge N drives serial_out low on edge N+1.
- Back-to-back words: the next pop can occur on the edge that ends the previous last stop bit. The minimum inter-word gap is therefore 0 clocks beyond the stop bits.
- rx_fifo_full_in rising mid-byte does not truncate the byte; it only gates the next start bit.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present; one parity bit follows each data byte. With PARITY_ODD=0 the bit is the XOR of the 8 data bits; with PARITY_ODD=1 it is the inverted XOR. Frame length is 1+8+1+STOP_BITS bits.
- Undefined: PARITY state and logic are absent; frame length is 1+8+STOP_BITS bits. PARITY_ODD is ignored.
- Ports are identical in both builds.

Decomposition:
- Package uart_tx_pkg:
  - state encoding constants (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, HOLD=3'd5);
  - MIN_DIV=2;
  - default divisor constant DIV_1M=200, for a 200 MHz clock at 1 Mbaud.
- One sub-module, sync_fifo_word: parametrised DATA_W × FIFO_DEPTH, single clock, asynchronous reset; provides full/empty/level; first-word registered output.
- The FSM, baud counter and shift register stay in uart_tx_word.

Test Plan:
- Single word: baud_div=4, STOP_BITS=1, parity off; write 32'hA5C3_0F81 to an idle block.
  - Required: serial_out low at the next edge.
  - Required: four 10-bit frames, bytes 81, 0F, C3, A5 LSB-first, 4 clocks per bit; busy high for exactly 160 clocks.
- Parity: UART_TX_PARITY_EN defined, PARITY_ODD=0, byte 8'h07.
  - Required: parity bit 1 after bit7.
  - Same byte with PARITY_ODD=1: parity bit 0.
- Flow control: assert rx_fifo_full_in during byte 1's data bits.
  - Required: byte 1 completes normally; line stays high in HOLD.
  - Required: start of byte 2 occurs one edge after rx_fifo_full_in deasserts.
- FIFO boundary: FIFO_DEPTH=16, hold asserted from reset; write 17 words.
  - Required: full=1 and level=16 after the 16th write; overflow pulses exactly once on write 17.
  - Release hold: 16 words transmitted in write order, then empty=1 and busy=0.
- Divisor edge cases:
  - baud_div=0 or 1: every bit lasts 2 clocks.
  - baud_div changed from 4 to 8 mid-word: the rest of the word stays at 4; the next word uses 8.
- Reset mid-frame: assert rst during bit3 of byte 2.
  - Required: serial_out=1 and busy=0 immediately; level=0.
  - Required: after release, no output until a new write.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encoding and divisor constants shared by the word UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    HOLD   = 3'd5
  } state_t;
  localparam int MIN_DIV = 2;
  localparam int DIV_1M  = 200;
endpackage

// File: rtl/sync_fifo_word.sv
// sync_fifo_word: single-clock word FIFO with occupancy count, first word presented on dout_o
module sync_fifo_word #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic [AW:0]       level_o
);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic push, pop;
  assign full_o = level_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign overflow_o = wr_en_i && full_o;
  assign push = wr_en_i && !full_o;
  assign pop = rd_en_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_word.sv
// uart_tx_word: FIFO-fed UART transmitter sending each word as LSB-first framed bytes.
// Define UART_TX_PARITY_EN to add a parity bit after each data byte.
module uart_tx_word import uart_tx_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              tx_clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              rx_fifo_full_in,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              serial_out,
  output logic              busy
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  state_t state_q;
  logic [DATA_W-1:0] sh_q, fifo_dout;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [2:0] bit_q;
  logic [BW-1:0] byte_q;
  logic tx_q, busy_q, tick, last_stop, word_end, pop;
`ifdef UART_TX_PARITY_EN
  logic par_q;
`endif
  sync_fifo_word #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(tx_clk_in), .rst(rst), .din_i(din), .wr_en_i(wr_en), .rd_en_i(pop),
    .dout_o(fifo_dout), .full_o(full), .empty_o(empty), .overflow_o(overflow), .level_o(level)
  );
  assign tick = cnt_q == div_q - 1'b1;
  assign last_stop = state_q == STOP && tick && bit_q == 3'(STOP_BITS - 1);
  assign word_end = last_stop && byte_q == BW'(BYTES - 1);
  // next word may pop on the very edge that ends the previous word's last stop bit
  assign pop = !empty && !rx_fifo_full_in && (state_q == IDLE || word_end);
  assign serial_out = tx_q;
  assign busy = busy_q;
  // data bits leave via a right shift, so the next byte sits at sh_q[7:0] after bit7
  always_ff @(posedge tx_clk_in or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      div_q <= DIV_W'(MIN_DIV);
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      cnt_q <= (tick || state_q == IDLE || state_q == HOLD) ? '0 : cnt_q + 1'b1;
      if (pop) begin
        state_q <= START;
        sh_q <= fifo_dout;
        div_q <= baud_div < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : baud_div;
        byte_q <= '0;
        tx_q <= 1'b0;
        busy_q <= 1'b1;
      end else case (state_q)
        START: if (tick) begin
          state_q <= DATA;
          bit_q <= '0;
          tx_q <= sh_q[0];
`ifdef UART_TX_PARITY_EN
          par_q <= sh_q[0];
`endif
        end
        DATA: if (tick) begin
          sh_q <= sh_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q <= par_q ^ 1'(PARITY_ODD);
`else
            state_q <= STOP;
            tx_q <= 1'b1;
            bit_q <= '0;
`endif
          end else begin
            bit_q <= bit_q + 1'b1;
            tx_q <= sh_q[1];
`ifdef UART_TX_PARITY_EN
            par_q <= par_q ^ sh_q[1];
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state_q <= STOP;
          tx_q <= 1'b1;
          bit_q <= '0;
        end
`endif
        STOP: if (tick) begin
          if (!last_stop) bit_q <= bit_q + 1'b1;
          else if (word_end) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end else begin
            byte_q <= byte_q + 1'b1;
            state_q <= rx_fifo_full_in ? HOLD : START;
            tx_q <= rx_fifo_full_in;
          end
        end
        HOLD: if (!rx_fifo_full_in) begin
          state_q <= START;
          tx_q <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: directed self-checking bench for uart_tx_word (default parameters)
module tb_uart_tx_word;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PO = 0;
  logic clk = 0, rst = 1, wr_en = 0, rx_full = 0;
  logic [31:0] din = '0;
  logic [15:0] baud_div = 16'd4;
  logic full, empty, overflow, serial_out, busy;
  logic [4:0] level;
  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, w_cyc = 0;

  uart_tx_word #(.DATA_W(32), .FIFO_DEPTH(16), .DIV_W(16), .STOP_BITS(1), .PARITY_ODD(PO)) dut (
    .tx_clk_in(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .rx_fifo_full_in(rx_full), .baud_div(baud_div),
    .serial_out(serial_out), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic do_reset();
    rst = 1;
    wr_en = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic write_word(input logic [31:0] w, output logic ov);
    @(posedge clk);
    #1 din = w;
    wr_en = 1;
    @(negedge clk);
    ov = overflow;
    @(posedge clk);
    #1 wr_en = 0;
    w_cyc = cyc;
  endtask

  task automatic capture_byte(input int div, output logic [7:0] d, output logic [NB-1:0] f,
                              output bit ok, output int st);
    int t;
    ok = 1;
    t = 0;
    f = '0;
    @(negedge clk);
    while (serial_out !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    st = cyc;
    if (serial_out !== 1'b0) ok = 0;
    else
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < div; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (k == 0) f[b] = serial_out;
          else if (serial_out !== f[b]) ok = 0;
        end
    d = f[8:1];
    if (f[0] !== 1'b0 || f[NB-1] !== 1'b1) ok = 0;
`ifdef UART_TX_PARITY_EN
    if (f[9] !== (^f[8:1] ^ 1'(PO))) ok = 0;
`endif
  endtask

  task automatic capture_word(input int div, output logic [31:0] w, output bit ok, output int st);
    logic [7:0] d;
    logic [NB-1:0] f;
    bit o;
    int s;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      capture_byte(div, d, f, o, s);
      if (i == 0) st = s;
      w[8*i +: 8] = d;
      if (!o) ok = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_line serial_out=%b busy=%b want 1 0", serial_out, busy);
    end
    checks++;
    if (full !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags full=%b empty=%b want 0 1", full, empty);
    end
    checks++;
    if (level !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_level level=%0d overflow=%b want 0 0", level, overflow);
    end
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_release serial_out=%b busy=%b empty=%b want 1 0 1", serial_out, busy, empty);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic ov;
    bit ok;
    int st, b0;
    baud_div = 16'd4;
    b0 = busy_cnt;
    write_word(32'hA5C3_0F81, ov);
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL single_pre_pop serial_out=%b want 1", serial_out);
    end
    capture_word(4, w, ok, st);
    checks++;
    if (st != w_cyc + 1) begin
      errors++;
      $display("FAIL single_latency start_edge=%0d want %0d", st, w_cyc + 1);
    end
    checks++;
    if (!ok || w !== 32'hA5C3_0F81) begin
      errors++;
      $display("FAIL single_data got %h framing_ok=%0d want a5c30f81 1", w, ok);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy_cnt - b0 != 4 * NB * 4) begin
      errors++;
      $display("FAIL single_busy_len got %0d want %0d", busy_cnt - b0, 4 * NB * 4);
    end
    checks++;
    if (busy !== 1'b0 || empty !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL single_idle busy=%b empty=%b line=%b want 0 1 1", busy, empty, serial_out);
    end
  endtask

  task automatic test_flow_control();
    logic [7:0] d0, d1, d2, d3;
    logic [NB-1:0] f;
    logic ov;
    bit ok0, ok1, ok2, ok3, held;
    int st, r;
    baud_div = 16'd4;
    write_word(32'h1234_5678, ov);
    capture_byte(4, d0, f, ok0, st);
    fork
      capture_byte(4, d1, f, ok1, st);
      begin
        repeat (10) @(negedge clk);
        rx_full = 1;
      end
    join
    checks++;
    if (!ok0 || !ok1 || d0 !== 8'h78 || d1 !== 8'h56) begin
      errors++;
      $display("FAIL flow_byte01 got %h %h ok=%0d%0d want 78 56 11", d0, d1, ok0, ok1);
    end
    held = 1;
    repeat (20) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b1) held = 0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL flow_hold line=%b busy=%b want 1 1 throughout", serial_out, busy);
    end
    @(posedge clk);
    #1 rx_full = 0;
    r = cyc;
    capture_byte(4, d2, f, ok2, st);
    checks++;
    if (st != r + 1) begin
      errors++;
      $display("FAIL flow_resume start_edge=%0d want %0d", st, r + 1);
    end
    capture_byte(4, d3, f, ok3, st);
    checks++;
    if (!ok2 || !ok3 || d2 !== 8'h34 || d3 !== 8'h12) begin
      errors++;
      $display("FAIL flow_byte23 got %h %h ok=%0d%0d want 34 12 11", d2, d3, ok2, ok3);
    end
  endtask

  task automatic test_fifo_boundary();
    logic [31:0] exp [16];
    logic [31:0] w;
    logic ov;
    int ovs, st, st0, bad;
    bit ok;
    do_reset();
    rx_full = 1;
    baud_div = 16'd2;
    ovs = 0;
    for (int i = 0; i < 16; i++) begin
      exp[i] = (i + 1) * 32'h0102_0408 ^ 32'h5A5A_0000;
      write_word(exp[i], ov);
      if (ov === 1'b1) ovs++;
    end
    @(negedge clk);
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || ovs != 0) begin
      errors++;
      $display("FAIL fifo_full full=%b level=%0d early_ovf=%0d want 1 16 0", full, level, ovs);
    end
    write_word(32'hDEAD_BEEF, ov);
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL fifo_overflow_pulse overflow=%b want 1", ov);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL fifo_after_ovf overflow=%b level=%0d want 0 16", overflow, level);
    end
    @(posedge clk);
    #1 rx_full = 0;
    bad = 0;
    st0 = 0;
    for (int i = 0; i < 16; i++) begin
      capture_word(2, w, ok, st);
      if (!ok || w !== exp[i]) begin
        bad++;
        $display("FAIL fifo_order word %0d got %h want %h ok=%0d", i, w, exp[i], ok);
      end
      if (i == 0) st0 = st;
      if (i == 1) begin
        checks++;
        if (st - st0 != 4 * NB * 2) begin
          errors++;
          $display("FAIL back_to_back gap got %0d want %0d", st - st0, 4 * NB * 2);
        end
      end
    end
    checks++;
    if (bad != 0) errors++;
    repeat (3) @(negedge clk);
    checks++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fifo_drained empty=%b busy=%b want 1 0", empty, busy);
    end
  endtask

  task automatic test_divisor();
    logic [31:0] w;
    logic [7:0] d;
    logic [NB-1:0] f;
    logic ov;
    bit ok, ok0;
    int st;
    baud_div = 16'd0;
    write_word(32'h3C5A_9601, ov);
    capture_word(2, w, ok, st);
    checks++;
    if (!ok || w !== 32'h3C5A_9601) begin
      errors++;
      $display("FAIL div0 got %h ok=%0d want 3c5a9601 1", w, ok);
    end
    baud_div = 16'd1;
    write_word(32'hFEDC_BA98, ov);
    capture_word(2, w, ok, st);
    checks++;
    if (!ok || w !== 32'hFEDC_BA98) begin
      errors++;
      $display("FAIL div1 got %h ok=%0d want fedcba98 1", w, ok);
    end
    rx_full = 1;
    write_word(32'h1122_3344, ov);
    write_word(32'h5566_7788, ov);
    baud_div = 16'd4;
    @(posedge clk);
    #1 rx_full = 0;
    capture_byte(4, d, f, ok0, st);
    baud_div = 16'd8;
    w[7:0] = d;
    for (int i = 1; i < 4; i++) begin
      capture_byte(4, d, f, ok, st);
      w[8*i +: 8] = d;
      if (!ok) ok0 = 0;
    end
    checks++;
    if (!ok0 || w !== 32'h1122_3344) begin
      errors++;
      $display("FAIL div_midword got %h ok=%0d want 11223344 1", w, ok0);
    end
    capture_word(8, w, ok, st);
    checks++;
    if (!ok || w !== 32'h5566_7788) begin
      errors++;
      $display("FAIL div_nextword got %h ok=%0d want 55667788 1", w, ok);
    end
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    logic [7:0] d;
    logic [NB-1:0] f;
    logic ov;
    bit ok;
    int st;
    baud_div = 16'd2;
    write_word(32'h0000_0007, ov);
    capture_byte(2, d, f, ok, st);
    checks++;
    if (d !== 8'h07 || f[9] !== (1'b1 ^ 1'(PO))) begin
      errors++;
      $display("FAIL parity got data %h parity %b want 07 %b", d, f[9], 1'b1 ^ 1'(PO));
    end
    repeat (3) capture_byte(2, d, f, ok, st);
`endif
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w;
    logic ov;
    bit ok, quiet;
    int p, st;
    baud_div = 16'd4;
    write_word(32'h0000_0000, ov);
    p = w_cyc + 1;
    write_word(32'hFFFF_FFFF, ov);
    while (cyc < p + 4 * NB * 2 + 4 + 13) @(negedge clk);
    checks++;
    if (serial_out !== 1'b0 || busy !== 1'b1 || level !== 5'd1) begin
      errors++;
      $display("FAIL midframe_pre line=%b busy=%b level=%0d want 0 1 1", serial_out, busy, level);
    end
    #1 rst = 1;
    #1;
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset line=%b busy=%b level=%0d empty=%b want 1 0 0 1",
               serial_out, busy, level, empty);
    end
    @(negedge clk);
    rst = 0;
    quiet = 1;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL midframe_quiet line=%b busy=%b want idle after reset", serial_out, busy);
    end
    write_word(32'hCAFE_F00D, ov);
    capture_word(4, w, ok, st);
    checks++;
    if (!ok || w !== 32'hCAFE_F00D || st != w_cyc + 1) begin
      errors++;
      $display("FAIL midframe_restart got %h ok=%0d start=%0d want cafef00d 1 %0d", w, ok, st, w_cyc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_flow_control();
    test_divisor();
    test_parity();
    test_fifo_boundary();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
